// File: rtl/autosa_glb_csb_initiator.sv
// CSB initiator: turns single host commands into csb2glb requests and matches the
// returning glb2csb response, with timeout and stray-response accounting.
module autosa_glb_csb_initiator #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_nposted,
  input  logic [21:0] cmd_addr,
  input  logic [31:0] cmd_wdat,
  input  logic [3:0]  cmd_wrbe,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdat,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        rsp_is_write,
  output logic        csb2glb_req_pvld,
  input  logic        csb2glb_req_prdy,
  output logic [62:0] csb2glb_req_pd,
  input  logic        glb2csb_resp_valid,
  input  logic [33:0] glb2csb_resp_pd,
  output logic [7:0]  stray_cnt
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REQ_PD_W  = 63;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned STRAY_W   = 8;
  localparam int unsigned PD_WRITE  = 54;
  localparam int unsigned PD_NPOST  = 55;
  localparam int unsigned RSP_ERR   = 32;
  localparam int unsigned RSP_TYPE  = 33;

  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [STRAY_W-1:0] STRAY_MAX = {STRAY_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [REQ_PD_W-1:0]   req_pd_q, req_pd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rsp_rdat_q, rsp_rdat_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  rsp_is_write_q, rsp_is_write_d;
  logic [STRAY_W-1:0]    stray_q, stray_d;
  logic                  issued_write;

  assign issued_write = req_pd_q[PD_WRITE];

  // Next-state and datapath update
  always_comb begin
    state_d        = state_q;
    req_pd_d       = req_pd_q;
    cnt_d          = cnt_q;
    rsp_rdat_d     = rsp_rdat_q;
    rsp_error_d    = rsp_error_q;
    rsp_timeout_d  = rsp_timeout_q;
    rsp_is_write_d = rsp_is_write_q;
    stray_d        = stray_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          req_pd_d = {2'b00, cmd_wrbe, 1'b0, cmd_nposted, cmd_write, cmd_wdat, cmd_addr};
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (csb2glb_req_prdy) begin
          if (issued_write && !req_pd_q[PD_NPOST]) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the timeout cycle still wins
        if (glb2csb_resp_valid) begin
          rsp_rdat_d     = issued_write ? '0 : glb2csb_resp_pd[DATA_W-1:0];
          rsp_error_d    = glb2csb_resp_pd[RSP_ERR] | (glb2csb_resp_pd[RSP_TYPE] != issued_write);
          rsp_timeout_d  = 1'b0;
          rsp_is_write_d = issued_write;
          state_d        = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_rdat_d     = '0;
          rsp_error_d    = 1'b1;
          rsp_timeout_d  = 1'b1;
          rsp_is_write_d = issued_write;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Responses arriving outside WAIT are dropped and counted
    if (glb2csb_resp_valid && (state_q != ST_WAIT) && (stray_q != STRAY_MAX)) begin
      stray_d = stray_q + STRAY_W'(1);
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q        <= ST_IDLE;
      req_pd_q       <= '0;
      cnt_q          <= '0;
      rsp_rdat_q     <= '0;
      rsp_error_q    <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      rsp_is_write_q <= 1'b0;
      stray_q        <= '0;
    end else begin
      state_q        <= state_d;
      req_pd_q       <= req_pd_d;
      cnt_q          <= cnt_d;
      rsp_rdat_q     <= rsp_rdat_d;
      rsp_error_q    <= rsp_error_d;
      rsp_timeout_q  <= rsp_timeout_d;
      rsp_is_write_q <= rsp_is_write_d;
      stray_q        <= stray_d;
    end
  end

  assign cmd_ready        = (state_q == ST_IDLE);
  assign csb2glb_req_pvld = (state_q == ST_REQ);
  assign rsp_valid        = (state_q == ST_RESP);
  assign csb2glb_req_pd   = req_pd_q;
  assign rsp_rdat         = rsp_rdat_q;
  assign rsp_error        = rsp_error_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign rsp_is_write     = rsp_is_write_q;
  assign stray_cnt        = stray_q;

endmodule

// File: tb/tb_autosa_glb_csb_initiator.sv
// Bench for autosa_glb_csb_initiator: directed vector table, hand-written reset and
// stray sequences, then randomized transactions against a transaction-level model.
module tb_autosa_glb_csb_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_nposted = 1'b0;
  logic [21:0] cmd_addr = '0;
  logic [31:0] cmd_wdat = '0;
  logic [3:0]  cmd_wrbe = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdat;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        rsp_is_write;
  logic        req_pvld;
  logic        req_prdy = 1'b0;
  logic [62:0] req_pd;
  logic        resp_valid = 1'b0;
  logic [33:0] resp_pd = '0;
  logic [7:0]  stray_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_stray = 0;

  autosa_glb_csb_initiator #(.TIMEOUT(TO)) dut (
    .autosa_core_clk   (clk),
    .autosa_core_rstn  (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_nposted       (cmd_nposted),
    .cmd_addr          (cmd_addr),
    .cmd_wdat          (cmd_wdat),
    .cmd_wrbe          (cmd_wrbe),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdat          (rsp_rdat),
    .rsp_error         (rsp_error),
    .rsp_timeout       (rsp_timeout),
    .rsp_is_write      (rsp_is_write),
    .csb2glb_req_pvld  (req_pvld),
    .csb2glb_req_prdy  (req_prdy),
    .csb2glb_req_pd    (req_pd),
    .glb2csb_resp_valid(resp_valid),
    .glb2csb_resp_pd   (resp_pd),
    .stray_cnt         (stray_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic        np;
    logic [21:0] addr;
    logic [31:0] wdat;
    logic [3:0]  be;
    int          prdy_dly;
    int          resp_dly;   // response at handshake edge + 1 + resp_dly
    logic        r_err;
    logic        r_type;
    logic [31:0] r_dat;
    int          rdy_dly;
    logic        stray;      // send one late response once back in IDLE
    logic        exp_rsp;
    logic [31:0] exp_rdat;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected host-side outcome of one transaction, straight from the protocol rules
  function automatic vec_t fill_exp(input vec_t v);
    vec_t r = v;
    r.exp_rsp = !(v.wr && !v.np);
    if (v.resp_dly >= TO) begin
      r.exp_rdat = '0;
      r.exp_err  = 1'b1;
      r.exp_to   = 1'b1;
    end else begin
      r.exp_rdat = v.wr ? 32'h0 : v.r_dat;
      r.exp_err  = v.r_err | (v.r_type != v.wr);
      r.exp_to   = 1'b0;
    end
    return r;
  endfunction

  task automatic chk_rsp_fields(input string tag, input vec_t v);
    chk({tag, " rsp_rdat"}, 64'(rsp_rdat), 64'(v.exp_rdat));
    chk({tag, " rsp_error"}, 64'(rsp_error), 64'(v.exp_err));
    chk({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
    chk({tag, " rsp_is_write"}, 64'(rsp_is_write), 64'(v.wr));
  endtask

  task automatic send_strays(input int n);
    resp_valid = 1'b1;
    resp_pd    = 34'h3_0000_00AA;
    repeat (n) @(negedge clk);
    resp_valid = 1'b0;
    exp_stray  = min_i(255, exp_stray + n);
    chk("stray_cnt", 64'(stray_cnt), 64'(exp_stray));
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    logic [62:0] exp_pd;
    logic [62:0] mask;
    int          acc;
    int          kend;
    exp_pd = {2'b00, v.be, 1'b0, v.np, v.wr, v.wdat, v.addr};
    mask   = v.wr ? {63{1'b1}} : ~(63'(1) << 55);
    @(negedge clk);
    chk({tag, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_nposted = v.np;
    cmd_addr = v.addr; cmd_wdat = v.wdat; cmd_wrbe = v.be;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
    for (int i = 0; i <= v.prdy_dly; i++) begin
      chk({tag, " req_pvld"}, 64'(req_pvld), 64'd1);
      chk({tag, " req_pd"}, 64'(req_pd & mask), 64'(exp_pd & mask));
      chk({tag, " cmd_ready busy"}, 64'(cmd_ready), 64'd0);
      req_prdy = (i == v.prdy_dly);
      @(negedge clk);
    end
    req_prdy = 1'b0;
    if (!v.exp_rsp) begin
      chk({tag, " posted pvld"}, 64'(req_pvld), 64'd0);
      chk({tag, " posted cmd_ready"}, 64'(cmd_ready), 64'd1);
      chk({tag, " posted rsp_valid"}, 64'(rsp_valid), 64'd0);
    end else begin
      kend = min_i(v.resp_dly, TO - 1);
      for (int k = 0; k <= kend; k++) begin
        chk({tag, " rsp_valid early"}, 64'(rsp_valid), 64'd0);
        resp_valid = (k == v.resp_dly);
        resp_pd    = {v.r_type, v.r_err, v.r_dat};
        @(negedge clk);
      end
      resp_valid = 1'b0;
      chk({tag, " latency"}, 64'(cyc - acc), 64'(v.prdy_dly + 1 + min_i(v.resp_dly + 1, TO)));
      chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk_rsp_fields(tag, v);
      for (int j = 0; j < v.rdy_dly; j++) begin
        @(negedge clk);
        chk({tag, " rsp_valid hold"}, 64'(rsp_valid), 64'd1);
        chk_rsp_fields({tag, " hold"}, v);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, " rsp_valid done"}, 64'(rsp_valid), 64'd0);
      chk({tag, " cmd_ready done"}, 64'(cmd_ready), 64'd1);
    end
    if (v.stray) send_strays(1);
    chk({tag, " stray_cnt"}, 64'(stray_cnt), 64'(exp_stray));
  endtask

  vec_t vecs[10];
  vec_t rv;

  initial begin
    //           wr    np    addr            wdat           be    pd rd err   type  r_dat          rdy stray exp_rsp exp_rdat   err   to
    vecs[0] = '{1'b0, 1'b0, 22'h000004,  32'h0,         4'h0, 0, 0, 1'b0, 1'b0, 32'h3,         0, 1'b0, 1'b1, 32'h3,        1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 22'h000010,  32'hA5A5_0001, 4'hF, 0, 0, 1'b0, 1'b1, 32'h0,         0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 22'h000020,  32'h1234_5678, 4'h3, 5, 0, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 22'h000030,  32'h0,         4'h0, 0, 20, 1'b0, 1'b0, 32'h55,       0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 22'h000040,  32'h0,         4'h0, 1, 2, 1'b0, 1'b1, 32'h1234,      0, 1'b0, 1'b1, 32'h1234,     1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 22'h3FFFFF,  32'h0,         4'h0, 0, 7, 1'b0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 22'h000050,  32'h0,         4'h0, 0, 3, 1'b0, 1'b0, 32'hCAFE_F00D, 10, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 22'h000060,  32'hFFFF_FFFF, 4'h1, 2, 1, 1'b1, 1'b1, 32'h99,        1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 22'h000070,  32'h1,         4'h8, 0, 0, 1'b0, 1'b0, 32'h77,        0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 22'h000080,  32'h5,         4'h2, 0, 9, 1'b0, 1'b1, 32'h0,         2, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1};

    #12;
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset req_pvld", 64'(req_pvld), 64'd0);
    chk("reset req_pd", 64'(req_pd), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdat", 64'(rsp_rdat), 64'd0);
    chk("reset rsp_error", 64'(rsp_error), 64'd0);
    chk("reset rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("reset rsp_is_write", 64'(rsp_is_write), 64'd0);
    chk("reset stray_cnt", 64'(stray_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Async reset while waiting for a response; late response becomes stray
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_nposted = 1'b0; cmd_addr = 22'h99;
    @(negedge clk);
    cmd_valid = 1'b0; req_prdy = 1'b1;
    @(negedge clk);
    req_prdy = 1'b0;
    @(negedge clk);
    chk("rst pre cmd_ready", 64'(cmd_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst stray_cnt", 64'(stray_cnt), 64'd0);
    exp_stray = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post-rst cmd_ready", 64'(cmd_ready), 64'd1);
    send_strays(1);

    // Saturation at 255 with the boundary on both sides
    send_strays(253);
    send_strays(1);
    send_strays(46);

    for (int n = 0; n < 60; n++) begin
      rv.wr       = 1'($urandom_range(0, 1));
      rv.np       = 1'($urandom_range(0, 1));
      rv.addr     = 22'($urandom);
      rv.wdat     = $urandom;
      rv.be       = 4'($urandom);
      rv.prdy_dly = int'($urandom_range(0, 3));
      rv.resp_dly = int'($urandom_range(0, 10));
      rv.r_err    = ($urandom_range(0, 7) == 0);
      rv.r_type   = rv.wr ^ ($urandom_range(0, 7) == 0);
      rv.r_dat    = $urandom;
      rv.rdy_dly  = int'($urandom_range(0, 3));
      rv.stray    = ($urandom_range(0, 3) == 0);
      rv = fill_exp(rv);
      run_txn($sformatf("rnd%0d", n), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
